// File: rtl/ama_riscv_mem_arb.sv
// rtl/ama_riscv_mem_arb.sv - fetch/data arbiter for a shared single-port fixed-latency memory
// Build option: define ARB_RR_EN for round-robin under contention (default: data port has fixed priority).
module ama_riscv_mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          if_flush,
  // data port
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic [AW-1:0] d_req_addr,
  input  logic [3:0]    d_req_we,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_data,
  // memory port
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_D  = 1'b1;

  logic               last_gnt;
  logic               d_wins;
  logic               gnt_if;
  logic               gnt_d;
  logic               rd_gnt;
  logic               fin_vld;
  logic               fin_src;
  logic [MEM_LAT-1:0] tag_vld;
  logic [MEM_LAT-1:0] tag_src;
  logic               unused_bits;

  // Contention winner: the port that was not granted last, or always data in fixed-priority builds.
  always_comb begin
`ifdef ARB_RR_EN
    d_wins = (last_gnt == SRC_IF);
`else
    d_wins = 1'b1;
`endif
  end

  // Combinational grant; nothing is granted while reset is held.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!rst) begin
      if (if_req_valid && d_req_valid) begin
        gnt_d  = d_wins;
        gnt_if = !d_wins;
      end else begin
        gnt_d  = d_req_valid;
        gnt_if = if_req_valid;
      end
    end
  end

  assign if_req_ready = gnt_if;
  assign d_req_ready  = gnt_d;

  // Winner drives the macro; fetch never writes. Address/wdata are don't-care when idle.
  assign mem_en    = gnt_if | gnt_d;
  assign mem_we    = gnt_d ? d_req_we : 4'b0000;
  assign mem_addr  = gnt_d ? d_req_addr[AW-1:2] : if_req_addr[AW-1:2];
  assign mem_wdata = d_req_wdata;

  // Only reads occupy a tag slot; writes complete on the grant cycle.
  assign rd_gnt = gnt_if | (gnt_d & (d_req_we == 4'b0000));

  // Remember which port won the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= SRC_IF;
    end else if (mem_en) begin
      last_gnt <= gnt_d ? SRC_D : SRC_IF;
    end
  end

  // Latency-matched tag pipeline; a flush kills fetch tags already in flight, not the one entering now.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_src <= '0;
    end else begin
      tag_vld[0] <= rd_gnt;
      tag_src[0] <= gnt_d ? SRC_D : SRC_IF;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1] && !(if_flush && (tag_src[i-1] == SRC_IF));
        tag_src[i] <= tag_src[i-1];
      end
    end
  end

  // Final stage steers the response; a flush in the response cycle suppresses a fetch response.
  assign fin_vld      = tag_vld[MEM_LAT-1] && !rst;
  assign fin_src      = tag_src[MEM_LAT-1];
  assign if_rsp_valid = fin_vld && (fin_src == SRC_IF) && !if_flush;
  assign d_rsp_valid  = fin_vld && (fin_src == SRC_D);
  assign if_rsp_data  = mem_rdata;
  assign d_rsp_data   = mem_rdata;

  // Byte-offset bits are ignored for word-aligned requests; last_gnt is idle without round-robin.
`ifdef ARB_RR_EN
  assign unused_bits = ^{if_req_addr[1:0], d_req_addr[1:0]};
`else
  assign unused_bits = ^{if_req_addr[1:0], d_req_addr[1:0], last_gnt};
`endif

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// tb/tb_ama_riscv_mem_arb.sv - scoreboard bench for ama_riscv_mem_arb (MEM_LAT = 2)
module tb_ama_riscv_mem_arb;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_valid = 1'b0;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          if_flush = 1'b0;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic [AW-1:0] d_req_addr = '0;
  logic [3:0]    d_req_we = '0;
  logic [DW-1:0] d_req_wdata = '0;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic exp_last = 1'b0;
  logic exp_gi;
  logic exp_gd;

  ama_riscv_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_flush(if_flush),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory contents: one fixed word, everything else distinct per address
  function automatic logic [31:0] mem_val(input logic [13:0] w);
    if (w == 14'h1000) return 32'hDEADBEEF;
    return {2'b10, w, 2'b01, ~w};
  endfunction

  // fixed-latency memory model
  logic [31:0] rp [LAT];
  always @(posedge clk) begin
    rp[0] <= (mem_en && mem_we == 4'b0000) ? mem_val(mem_addr) : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign mem_rdata = rp[LAT-1];

  // response monitor: pops the scoreboard at the cycle each response is due
  always @(negedge clk) begin
    exp_t e;
    if (if_rsp_valid || d_rsp_valid) begin
      checks++;
      if (if_rsp_valid && d_rsp_valid) begin
        failures++;
        $display("FAIL rsp_both cyc=%0d got if=1 d=1 exp one-hot", cyc);
      end else if (sb.size() == 0 || sb[0].due != cyc) begin
        failures++;
        $display("FAIL rsp_unexpected cyc=%0d got port=%0d exp none (next due=%0d)",
                 cyc, d_rsp_valid, sb.size() ? sb[0].due : -1);
      end else begin
        e = sb.pop_front();
        if (d_rsp_valid !== e.port ||
            (e.port ? d_rsp_data : if_rsp_data) !== e.data) begin
          failures++;
          $display("FAIL rsp_data cyc=%0d got port=%0d data=%h exp port=%0d data=%h",
                   cyc, d_rsp_valid, e.port ? d_rsp_data : if_rsp_data, e.port, e.data);
        end
      end
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      checks++;
      failures++;
      e = sb.pop_front();
      $display("FAIL rsp_missing cyc=%0d got none exp port=%0d data=%h", cyc, e.port, e.data);
    end
  end

  // drive one cycle of stimulus and update the reference model
  task automatic step(input logic iv, input logic [15:0] ia, input logic dv, input logic [15:0] da,
                      input logic [3:0] dwe, input logic [31:0] dwd, input logic fl, input logic r);
    exp_t keep[$];
    @(posedge clk);
    #1;
    rst = r; if_req_valid = iv; if_req_addr = ia; if_flush = fl;
    d_req_valid = dv; d_req_addr = da; d_req_we = dwe; d_req_wdata = dwd;
    exp_gi = 1'b0;
    exp_gd = 1'b0;
    if (r) begin
      sb.delete();
      exp_last = 1'b0;
    end else begin
      if (fl) begin
        foreach (sb[i]) if (!(sb[i].port == 1'b0 && sb[i].due < cyc + LAT)) keep.push_back(sb[i]);
        sb = keep;
      end
      if (iv && dv) begin
`ifdef ARB_RR_EN
        exp_gd = (exp_last == 1'b0);
`else
        exp_gd = 1'b1;
`endif
        exp_gi = !exp_gd;
      end else begin
        exp_gi = iv;
        exp_gd = dv;
      end
      if (exp_gi) sb.push_back('{1'b0, mem_val(ia[15:2]), cyc + LAT});
      if (exp_gd && dwe == 4'b0000) sb.push_back('{1'b1, mem_val(da[15:2]), cyc + LAT});
      if (exp_gi || exp_gd) exp_last = exp_gd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 16'h0, 4'h0, 32'h0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 16'h0040, 1, 16'h0080, 4'hF, 32'hFFFF_FFFF, 0, 1);
      @(negedge clk);
      checks++;
      if ({if_req_ready, d_req_ready, mem_en, mem_we, if_rsp_valid, d_rsp_valid} !== 9'b0) begin
        failures++;
        $display("FAIL reset_outputs got rdy=%b%b en=%b we=%b rsp=%b%b exp all 0",
                 if_req_ready, d_req_ready, mem_en, mem_we, if_rsp_valid, d_rsp_valid);
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] pat;
`ifdef ARB_RR_EN
    pat = 4'b0101;
`else
    pat = 4'b1111;
`endif
    step(1, 16'h0300, 0, 16'h0, 4'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL contention_pre if_ready got=%b exp=1", if_req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 16'h0400, 1, 16'h0500, 4'h0, 32'h0, 0, 0);
      @(negedge clk);
      checks++;
      if (d_req_ready !== pat[i] || if_req_ready !== !pat[i] ||
          mem_addr !== (pat[i] ? 14'h0140 : 14'h0100)) begin
        failures++;
        $display("FAIL contention_%0d got d_rdy=%b if_rdy=%b addr=%h exp d_rdy=%b if_rdy=%b addr=%h",
                 i, d_req_ready, if_req_ready, mem_addr, pat[i], !pat[i],
                 pat[i] ? 14'h0140 : 14'h0100);
      end
    end
    idle(LAT + 1);
  endtask

  task automatic test_fetch_read();
    step(1, 16'h4000, 0, 16'h0, 4'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0 || mem_en !== 1'b1 ||
        mem_we !== 4'h0 || mem_addr !== 14'h1000) begin
      failures++;
      $display("FAIL fetch_read got rdy=%b%b en=%b we=%h addr=%h exp rdy=10 en=1 we=0 addr=1000",
               if_req_ready, d_req_ready, mem_en, mem_we, mem_addr);
    end
    idle(LAT + 1);
  endtask

  task automatic test_data_write();
    step(0, 16'h0, 1, 16'h0010, 4'b0011, 32'h12345678, 0, 0);
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0011 ||
        mem_addr !== 14'h0004 || mem_wdata !== 32'h12345678) begin
      failures++;
      $display("FAIL data_write got rdy=%b en=%b we=%b addr=%h wd=%h exp rdy=1 en=1 we=0011 addr=0004 wd=12345678",
               d_req_ready, mem_en, mem_we, mem_addr, mem_wdata);
    end
    idle(LAT + 1);
  endtask

  task automatic test_flush();
    step(1, 16'h0700, 0, 16'h0, 4'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_fetch_gnt got=%b exp=1", if_req_ready);
    end
    step(0, 16'h0, 1, 16'h0800, 4'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_data_gnt got=%b exp=1", d_req_ready);
    end
    step(1, 16'h0900, 0, 16'h0, 4'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_same_cycle_gnt got=%b exp=1", if_req_ready);
    end
    idle(1);
    step(1, 16'h0A00, 0, 16'h0, 4'h0, 32'h0, 0, 0);
    idle(1);
    step(0, 16'h0, 0, 16'h0, 4'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_final_stage got if_rsp_valid=%b exp=0", if_rsp_valid);
    end
    idle(LAT + 1);
  endtask

  task automatic test_reset_mid();
    step(0, 16'h0, 1, 16'h0600, 4'h0, 32'h0, 0, 0);
    step(0, 16'h0, 0, 16'h0, 4'h0, 32'h0, 0, 1);
    step(0, 16'h0, 0, 16'h0, 4'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++;
    if ({if_req_ready, d_req_ready, mem_en, mem_we, if_rsp_valid, d_rsp_valid} !== 9'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got rdy=%b%b en=%b we=%b rsp=%b%b exp all 0",
               if_req_ready, d_req_ready, mem_en, mem_we, if_rsp_valid, d_rsp_valid);
    end
    step(1, 16'h0610, 1, 16'h0620, 4'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_last_gnt got d_rdy=%b if_rdy=%b exp d_rdy=1 if_rdy=0",
               d_req_ready, if_req_ready);
    end
    idle(LAT + 2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 16'h1000 + 16'(i * 4), 0, 16'h0, 4'h0, 32'h0, 0, 0);
      else            step(0, 16'h0, 1, 16'h2000 + 16'(i * 4), 4'h0, 32'h0, 0, 0);
      @(negedge clk);
      checks++;
      if (if_req_ready !== (i % 2 == 0) || d_req_ready !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL b2b_gnt_%0d got if_rdy=%b d_rdy=%b exp if_rdy=%b d_rdy=%b",
                 i, if_req_ready, d_req_ready, (i % 2 == 0), (i % 2 == 1));
      end
    end
    idle(LAT + 2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_fetch_read();
    test_data_write();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
